odd_pipe_issue_ctrl: RTL and testbench

//  Issue controller for the odd (shift/rotate) pipe. Buffers decoded odd-pipe instructions in a FIFO.

---
 rtl/odd_pipe_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_odd_pipe_issue_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_pipe_issue_ctrl.sv
// odd_pipe_issue_ctrl
//   Issue controller for the odd (shift/rotate) pipe. Decoded instructions are
//   buffered in a small in-order FIFO. A PIPE_DEPTH-deep scoreboard shift
//   register remembers which destination registers are still in flight. The
//   FIFO head issues combinationally unless one of its sources matches an
//   in-flight destination (RAW hazard, no forwarding).
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     flush             drop all buffered (not yet issued) instructions
//     in_valid/in_ready decode handshake; in_ready depends only on the count
//     in_*              decoded instruction fields
//     iss_*             instruction presented to odd_pipe this cycle
//     fifo_count        number of buffered entries
//     stall_cnt         saturating count of hazard-stall cycles
module odd_pipe_issue_ctrl #(
  parameter int OPCODE_LEN  = 11,
  parameter int REG_ADDR_WD = 7,
  parameter int FIFO_DEPTH  = 4,
  parameter int PIPE_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OPCODE_LEN-1:0]         in_opcode,
  input  logic [REG_ADDR_WD-1:0]        in_ra_addr,
  input  logic [REG_ADDR_WD-1:0]        in_rb_addr,
  input  logic                          in_uses_ra,
  input  logic                          in_uses_rb,
  input  logic [REG_ADDR_WD-1:0]        in_rt_addr,
  input  logic                          in_rt_we,
  input  logic [17:0]                   in_imm,
  output logic                          iss_valid,
  output logic [OPCODE_LEN-1:0]         iss_opcode,
  output logic [REG_ADDR_WD-1:0]        iss_ra_addr,
  output logic [REG_ADDR_WD-1:0]        iss_rb_addr,
  output logic [REG_ADDR_WD-1:0]        iss_rt_addr,
  output logic                          iss_rt_we,
  output logic [17:0]                   iss_imm,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [OPCODE_LEN-1:0]  opcode;
    logic [REG_ADDR_WD-1:0] ra;
    logic [REG_ADDR_WD-1:0] rb;
    logic                   uses_ra;
    logic                   uses_rb;
    logic [REG_ADDR_WD-1:0] rt;
    logic                   rt_we;
    logic [17:0]            imm;
  } entry_t;

  // Instruction buffer (data only, no reset) and its control state.
  entry_t                 fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Scoreboard: valid bits are control (reset), addresses are data.
  logic [PIPE_DEPTH-1:0]  sb_v_q, sb_v_d;
  logic [REG_ADDR_WD-1:0] sb_addr_q [PIPE_DEPTH];

  logic [15:0]            stall_q, stall_d;

  entry_t in_entry;
  entry_t head;
  logic   empty;
  logic   hazard;
  logic   push;
  logic   pop;
  logic   stall_inc;

  assign in_entry = '{opcode:  in_opcode,
                      ra:      in_ra_addr,
                      rb:      in_rb_addr,
                      uses_ra: in_uses_ra,
                      uses_rb: in_uses_rb,
                      rt:      in_rt_addr,
                      rt_we:   in_rt_we,
                      imm:     in_imm};

  assign head     = fifo_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign in_ready = (count_q < DEPTH_C);

  // RAW check of the head against every in-flight destination.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (sb_v_q[k] &&
          ((head.uses_ra && (sb_addr_q[k] == head.ra)) ||
           (head.uses_rb && (sb_addr_q[k] == head.rb)))) begin
        hazard = 1'b1;
      end
    end
  end

  // Holding iss_valid low during reset keeps a stale head from reaching odd_pipe.
  assign iss_valid = !rst && !empty && !hazard && !flush;
  assign pop       = iss_valid;
  assign push      = in_valid && in_ready && !flush;
  assign stall_inc = !empty && hazard && !flush;

  assign iss_opcode  = iss_valid ? head.opcode : '0;
  assign iss_ra_addr = iss_valid ? head.ra     : '0;
  assign iss_rb_addr = iss_valid ? head.rb     : '0;
  assign iss_rt_addr = iss_valid ? head.rt     : '0;
  assign iss_rt_we   = iss_valid && head.rt_we;
  assign iss_imm     = iss_valid ? head.imm    : '0;

  assign fifo_count = count_q;
  assign stall_cnt  = stall_q;

  // Next-state for the FIFO control, scoreboard valids and stall counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    sb_v_d   = {sb_v_q[PIPE_DEPTH-2:0], iss_rt_we};

    if (flush) begin
      // Everything buffered is discarded; in-flight tracking is untouched.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (stall_inc && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sb_v_q   <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sb_v_q   <= sb_v_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk) begin
    sb_addr_q[0] <= head.rt;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      sb_addr_q[k] <= sb_addr_q[k-1];
    end
  end

endmodule

// File: tb/tb_odd_pipe_issue_ctrl.sv
module tb_odd_pipe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_opcode = '0;
  logic [6:0]  in_ra_addr = '0;
  logic [6:0]  in_rb_addr = '0;
  logic        in_uses_ra = 1'b0;
  logic        in_uses_rb = 1'b0;
  logic [6:0]  in_rt_addr = '0;
  logic        in_rt_we = 1'b0;
  logic [17:0] in_imm = '0;
  logic        iss_valid;
  logic [10:0] iss_opcode;
  logic [6:0]  iss_ra_addr;
  logic [6:0]  iss_rb_addr;
  logic [6:0]  iss_rt_addr;
  logic        iss_rt_we;
  logic [17:0] iss_imm;
  logic [2:0]  fifo_count;
  logic [15:0] stall_cnt;

  odd_pipe_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
    .in_uses_ra(in_uses_ra), .in_uses_rb(in_uses_rb),
    .in_rt_addr(in_rt_addr), .in_rt_we(in_rt_we), .in_imm(in_imm),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode),
    .iss_ra_addr(iss_ra_addr), .iss_rb_addr(iss_rb_addr),
    .iss_rt_addr(iss_rt_addr), .iss_rt_we(iss_rt_we), .iss_imm(iss_imm),
    .fifo_count(fifo_count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] op;
    logic [6:0]  ra, rb, rt;
    bit          ura, urb, we;
    logic [17:0] imm;
  } ins_t;

  // Reference model: an in-order queue plus, per register, the cycle in which
  // its most recent writer issued. A reader is blocked while fewer than
  // PIPE_DEPTH+1 cycles have passed since that issue.
  ins_t q[$];
  int   last_wr[128];
  int   stall_m;
  int   cyc;
  int   dut_iss_cyc;
  int   n_chk;
  int   n_pass;

  localparam int PD = 8;
  localparam int FD = 4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic ins_t mk(int op, int ra, int rb, bit ura, bit urb, int rt, bit we, int imm);
    ins_t i;
    i.op  = 11'(op);
    i.ra  = 7'(ra);
    i.rb  = 7'(rb);
    i.ura = ura;
    i.urb = urb;
    i.rt  = 7'(rt);
    i.we  = we;
    i.imm = 18'(imm);
    return i;
  endfunction

  function automatic ins_t rnd();
    return mk($urandom_range(1, 2047), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
              $urandom_range(0, 262143));
  endfunction

  task automatic model_clear();
    q.delete();
    for (int r = 0; r < 128; r++) last_wr[r] = -1000;
    stall_m = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    cyc++;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic cycle(input bit v, input bit fl, input ins_t ins);
    bit   haz, exp_ready, exp_iss;
    ins_t h;
    in_valid   = v;
    flush      = fl;
    in_opcode  = ins.op;
    in_ra_addr = ins.ra;
    in_rb_addr = ins.rb;
    in_uses_ra = ins.ura;
    in_uses_rb = ins.urb;
    in_rt_addr = ins.rt;
    in_rt_we   = ins.we;
    in_imm     = ins.imm;
    #2;
    haz = 1'b0;
    h   = mk(0, 0, 0, 0, 0, 0, 0, 0);
    if (q.size() > 0) begin
      h = q[0];
      if (h.ura && (cyc - last_wr[h.ra] <= PD)) haz = 1'b1;
      if (h.urb && (cyc - last_wr[h.rb] <= PD)) haz = 1'b1;
    end
    exp_ready = (q.size() < FD);
    exp_iss   = (q.size() > 0) && !haz && !fl;

    chk("in_ready",   in_ready,   exp_ready);
    chk("fifo_count", fifo_count, q.size());
    chk("stall_cnt",  stall_cnt,  stall_m);
    chk("iss_valid",  iss_valid,  exp_iss);
    if (exp_iss) begin
      chk("iss_opcode", iss_opcode,  h.op);
      chk("iss_ra",     iss_ra_addr, h.ra);
      chk("iss_rb",     iss_rb_addr, h.rb);
      chk("iss_rt",     iss_rt_addr, h.rt);
      chk("iss_rt_we",  iss_rt_we,   h.we);
      chk("iss_imm",    iss_imm,     h.imm);
    end else begin
      chk("nop_opcode", iss_opcode, 0);
      chk("nop_rt_we",  iss_rt_we,  0);
    end
    if (iss_valid === 1'b1) dut_iss_cyc = cyc;

    if ((q.size() > 0) && haz && !fl && (stall_m != 65535)) stall_m++;
    if (fl) begin
      q.delete();
    end else begin
      if (exp_iss) begin
        if (h.we) last_wr[h.rt] = cyc;
        void'(q.pop_front());
      end
      if (v && exp_ready) q.push_back(ins);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    int tp;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    dut_iss_cyc = -1;
    model_clear();

    // Reset state.
    do_reset();
    chk("rst_ready",  in_ready,   1);
    chk("rst_iss",    iss_valid,  0);
    chk("rst_count",  fifo_count, 0);
    chk("rst_stall",  stall_cnt,  0);
    chk("rst_opcode", iss_opcode, 0);

    // Four independent ops back to back, then drain in order.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, mk(k + 1, 10 + k, 11 + k, 1, 1, 20 + k, 1, k));
    idle(3);

    // Full buffer: head stalls on r30 while readers pile up; fifth push dropped.
    do_reset();
    cycle(1'b1, 1'b0, mk(100, 0, 0, 0, 0, 30, 1, 0));
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, mk(101 + k, 30, 1, 1, 0, 40 + k, 1, k));
    chk("full_ready", in_ready, 0);
    idle(14);

    // Producer r5 then dependent reader; issues exactly PIPE_DEPTH+1 later.
    do_reset();
    cycle(1'b1, 1'b0, mk(200, 0, 0, 0, 0, 5, 1, 0));
    tp = cyc;
    idle(1);
    cycle(1'b1, 1'b0, mk(201, 5, 0, 1, 0, 6, 1, 0));
    idle(10);
    chk("raw_issue_cyc", dut_iss_cyc, tp + 9);
    chk("raw_stall_cnt", stall_cnt, 7);

    // Same addresses but sources unused: no stall.
    do_reset();
    cycle(1'b1, 1'b0, mk(210, 0, 0, 0, 0, 5, 1, 0));
    tp = cyc;
    cycle(1'b1, 1'b0, mk(211, 5, 5, 0, 0, 6, 1, 0));
    idle(2);
    chk("nouse_issue_cyc", dut_iss_cyc, tp + 1);
    chk("nouse_stall_cnt", stall_cnt, 0);

    // Producer without write enable does not block a reader.
    do_reset();
    cycle(1'b1, 1'b0, mk(220, 0, 0, 0, 0, 9, 0, 0));
    tp = cyc;
    cycle(1'b1, 1'b0, mk(221, 9, 9, 1, 1, 6, 1, 0));
    idle(2);
    chk("nowe_issue_cyc", dut_iss_cyc, tp + 1);
    chk("nowe_stall_cnt", stall_cnt, 0);

    // Flush with three stalled entries and a same-cycle push.
    do_reset();
    cycle(1'b1, 1'b0, mk(230, 0, 0, 0, 0, 40, 1, 0));
    tp = cyc;
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, mk(231 + k, 40, 0, 1, 0, 50, 1, 0));
    cycle(1'b1, 1'b1, mk(240, 0, 0, 0, 0, 51, 1, 0));
    chk("flush_count", fifo_count, 0);
    chk("flush_iss",   iss_valid,  0);
    cycle(1'b1, 1'b0, mk(241, 0, 40, 0, 1, 52, 1, 0));
    idle(8);
    chk("flush_issue_cyc", dut_iss_cyc, tp + 9);

    // Reset in the middle of a stall clears buffer and scoreboard.
    do_reset();
    cycle(1'b1, 1'b0, mk(250, 0, 0, 0, 0, 50, 1, 0));
    idle(1);
    for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0, mk(251 + k, 50, 0, 1, 0, 60, 1, 0));
    idle(1);
    do_reset();
    chk("mrst_count", fifo_count, 0);
    chk("mrst_iss",   iss_valid,  0);
    chk("mrst_stall", stall_cnt,  0);
    tp = cyc;
    cycle(1'b1, 1'b0, mk(260, 50, 50, 1, 1, 61, 1, 0));
    idle(2);
    chk("mrst_issue_cyc", dut_iss_cyc, tp + 1);

    // Randomised traffic with small register range to provoke hazards.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, rnd());
      end
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
